config_frame_writer: RTL and testbench

//  Drives the column config-memory write interface: FrameData, one-hot FrameStrobe and one-hot ColSelect.

---
 rtl/config_frame_writer.sv | 135 +++++++++++++
 tb/tb_config_frame_writer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_frame_writer.sv
// Column config-memory frame writer: parses SYNC/header/data words from a valid/ready
// stream and sequences FrameData setup, a one-hot FrameStrobe pulse and a hold cycle.
module config_frame_writer #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumColumns      = 16,
  parameter int StrobeCycles    = 1
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic [31:0]                s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [NumColumns-1:0]      ColSelect,
  output logic                       busy,
  output logic                       error,
  output logic [15:0]                frames_written
);

  localparam logic [31:0] SyncWord   = 32'hFAB0_FAB1;
  localparam logic [31:0] DesyncWord = 32'hFAB0_FAB0;

  typedef enum logic [2:0] {
    Idle,
    Header,
    Data,
    Setup,
    Strobe,
    Hold
  } state_t;

  state_t      state;
  logic [7:0]  colIdx;
  logic [4:0]  frameIdx;
  logic        discard;
  logic [7:0]  cnt;
  logic        accept;
  logic        headerOk;

  assign accept   = s_valid && s_ready;
  assign headerOk = (s_data[31:16] == 16'h0000) && (s_data[7:5] == 3'b000) &&
                    (int'(s_data[15:8]) < NumColumns) &&
                    (int'(s_data[4:0]) < MaxFramesPerCol);

  // Outputs are registered alongside the state, so each is set on the transition into its state.
  // Setup spans two cycles so the strobe lands at accept+3 and a frame takes six cycles end to end.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state          <= Idle;
      colIdx         <= '0;
      frameIdx       <= '0;
      discard        <= 1'b0;
      cnt            <= '0;
      s_ready        <= 1'b0;
      FrameData      <= '0;
      FrameStrobe    <= '0;
      ColSelect      <= '0;
      busy           <= 1'b0;
      error          <= 1'b0;
      frames_written <= '0;
    end else begin
      case (state)
        Idle: begin
          s_ready <= 1'b1;
          if (accept && s_data == SyncWord) state <= Header;
        end
        Header: begin
          if (accept) begin
            if (s_data == DesyncWord) begin
              state <= Idle;
            end else if (s_data == SyncWord) begin
              state <= Header;
            end else if (headerOk) begin
              colIdx   <= s_data[15:8];
              frameIdx <= s_data[4:0];
              discard  <= 1'b0;
              state    <= Data;
            end else begin
              error   <= 1'b1;
              discard <= 1'b1;
              state   <= Data;
            end
          end
        end
        Data: begin
          // The payload is taken verbatim; SYNC/DESYNC patterns have no meaning here.
          if (accept) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= Header;
            end else begin
              FrameData <= s_data[FrameBitsPerRow-1:0];
              ColSelect <= NumColumns'(1) << colIdx;
              s_ready   <= 1'b0;
              busy      <= 1'b1;
              cnt       <= '0;
              state     <= Setup;
            end
          end
        end
        Setup: begin
          if (cnt == 8'd1) begin
            cnt         <= '0;
            FrameStrobe <= MaxFramesPerCol'(1) << frameIdx;
            state       <= Strobe;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        Strobe: begin
          if (cnt == 8'(StrobeCycles - 1)) begin
            cnt            <= '0;
            FrameStrobe    <= '0;
            frames_written <= frames_written + 16'd1;
            state          <= Hold;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        Hold: begin
          ColSelect <= '0;
          busy      <= 1'b0;
          s_ready   <= 1'b1;
          state     <= Header;
        end
        default: begin
          state <= Idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_frame_writer.sv
// Directed bench for config_frame_writer: one instance with a 1-cycle strobe, one with a 3-cycle strobe.
module tb_config_frame_writer;

  localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

  logic        CLK = 1'b0;
  logic        resetn;
  logic [31:0] sData, sData3;
  logic        sValid, sValid3;
  logic        sReady, sReady3;
  logic [31:0] frameData, frameData3;
  logic [19:0] frameStrobe, frameStrobe3;
  logic [15:0] colSelect, colSelect3;
  logic        busy, busy3, error, error3;
  logic [15:0] framesWritten, framesWritten3;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  config_frame_writer #(.StrobeCycles(1)) dut (
    .CLK(CLK), .resetn(resetn), .s_data(sData), .s_valid(sValid), .s_ready(sReady),
    .FrameData(frameData), .FrameStrobe(frameStrobe), .ColSelect(colSelect),
    .busy(busy), .error(error), .frames_written(framesWritten)
  );

  config_frame_writer #(.StrobeCycles(3)) dut3 (
    .CLK(CLK), .resetn(resetn), .s_data(sData3), .s_valid(sValid3), .s_ready(sReady3),
    .FrameData(frameData3), .FrameStrobe(frameStrobe3), .ColSelect(colSelect3),
    .busy(busy3), .error(error3), .frames_written(framesWritten3)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    sData  = w;
    sValid = 1'b1;
    while (!sReady && n < 20) begin
      tick();
      n++;
    end
    if (!sReady) begin
      checks++;
      failures++;
      $display("FAIL send_timeout word=%h s_ready=%b required=1", w, sReady);
    end
    tick();
    sValid = 1'b0;
  endtask

  task automatic doReset();
    sValid  = 1'b0;
    sValid3 = 1'b0;
    resetn  = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #1;
    tick();
    checks++;
    if ({sReady, frameData, frameStrobe, colSelect, busy, error, framesWritten} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b fd=%h fs=%h cs=%h busy=%b err=%b fw=%0d required all 0",
               sReady, frameData, frameStrobe, colSelect, busy, error, framesWritten);
    end
    checks++;
    if ({sReady3, frameStrobe3, busy3, framesWritten3} !== '0) begin
      failures++;
      $display("FAIL reset_outputs3 got rdy=%b fs=%h busy=%b fw=%0d required all 0",
               sReady3, frameStrobe3, busy3, framesWritten3);
    end
    resetn = 1'b1;
  endtask

  task automatic test_basic_write();
    send(SYNC);
    send(32'h0000_0305);
    send(32'hDEAD_BEEF);
    checks++;
    if (frameData !== 32'hDEAD_BEEF || colSelect !== 16'h0008) begin
      failures++;
      $display("FAIL basic_setup_data fd=%h cs=%h required DEADBEEF/0008", frameData, colSelect);
    end
    checks++;
    if (frameStrobe !== 20'h0 || busy !== 1'b1 || sReady !== 1'b0) begin
      failures++;
      $display("FAIL basic_setup_ctrl fs=%h busy=%b rdy=%b required 00000/1/0", frameStrobe, busy, sReady);
    end
    tick();
    checks++;
    if (frameStrobe !== 20'h0) begin
      failures++;
      $display("FAIL basic_t2_strobe got=%h required=00000", frameStrobe);
    end
    tick();
    checks++;
    if (frameStrobe !== 20'h00020) begin
      failures++;
      $display("FAIL basic_t3_strobe got=%h required=00020", frameStrobe);
    end
    tick();
    checks++;
    if (frameStrobe !== 20'h0 || framesWritten !== 16'd1 || colSelect !== 16'h0008) begin
      failures++;
      $display("FAIL basic_hold fs=%h fw=%0d cs=%h required 00000/1/0008", frameStrobe, framesWritten, colSelect);
    end
    tick();
    checks++;
    if (colSelect !== 16'h0 || sReady !== 1'b1 || busy !== 1'b0 || frameData !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL basic_after cs=%h rdy=%b busy=%b fd=%h required 0000/1/0/DEADBEEF",
               colSelect, sReady, busy, frameData);
    end
  endtask

  task automatic test_pre_sync();
    logic [19:0] seen;
    doReset();
    send(32'h0000_1234);
    send(DESYNC);
    send(32'h0000_0102);
    send(32'h5555_AAAA);
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      seen |= frameStrobe;
      tick();
    end
    checks++;
    if (seen !== 20'h0 || error !== 1'b0 || framesWritten !== 16'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL pre_sync_ignored strobes=%h err=%b fw=%0d busy=%b required 00000/0/0/0",
               seen, error, framesWritten, busy);
    end
  endtask

  task automatic test_bad_header();
    logic [19:0] seen;
    doReset();
    send(SYNC);
    send(32'h0000_1005);
    checks++;
    if (error !== 1'b1) begin
      failures++;
      $display("FAIL bad_header_error got=%b required=1", error);
    end
    send(32'hAAAA_5555);
    seen = '0;
    for (int i = 0; i < 5; i++) begin
      seen |= frameStrobe;
      tick();
    end
    checks++;
    if (seen !== 20'h0 || framesWritten !== 16'd0 || frameData !== 32'h0) begin
      failures++;
      $display("FAIL bad_header_nowrite strobes=%h fw=%0d fd=%h required 00000/0/00000000",
               seen, framesWritten, frameData);
    end
    send(32'h0000_0F13);
    send(32'h1234_5678);
    tick();
    tick();
    checks++;
    if (frameStrobe !== 20'h80000 || colSelect !== 16'h8000 || frameData !== 32'h1234_5678) begin
      failures++;
      $display("FAIL bad_header_recover fs=%h cs=%h fd=%h required 80000/8000/12345678",
               frameStrobe, colSelect, frameData);
    end
    tick();
    checks++;
    if (framesWritten !== 16'd1 || error !== 1'b1) begin
      failures++;
      $display("FAIL bad_header_sticky fw=%0d err=%b required 1/1", framesWritten, error);
    end
  endtask

  task automatic test_long_strobe();
    logic [31:0] words [3];
    logic [19:0] expStrobe;
    int          n;
    int          hits;
    words[0] = SYNC;
    words[1] = 32'h0000_0201;
    words[2] = 32'hCAFE_F00D;
    doReset();
    sValid3 = 1'b1;
    for (int w = 0; w < 3; w++) begin
      sData3 = words[w];
      n = 0;
      while (!sReady3 && n < 20) begin
        tick();
        n++;
      end
      if (!sReady3) begin
        checks++;
        failures++;
        $display("FAIL long_send_timeout word=%h s_ready=%b required=1", words[w], sReady3);
      end
      tick();
    end
    sData3 = 32'h0000_0000;
    hits = 0;
    for (int k = 1; k <= 7; k++) begin
      expStrobe = (k >= 3 && k <= 5) ? 20'h00002 : 20'h0;
      if (frameStrobe3 == 20'h00002) hits++;
      checks++;
      if (frameStrobe3 !== expStrobe || sReady3 !== (k == 7)) begin
        failures++;
        $display("FAIL long_cycle%0d fs=%h rdy=%b required %h/%b", k, frameStrobe3, sReady3, expStrobe, (k == 7));
      end
      if (k <= 6) begin
        checks++;
        if (frameData3 !== 32'hCAFE_F00D || colSelect3 !== 16'h0004 || busy3 !== 1'b1) begin
          failures++;
          $display("FAIL long_stable%0d fd=%h cs=%h busy=%b required CAFEF00D/0004/1", k, frameData3, colSelect3, busy3);
        end
      end
      if (k < 7) tick();
    end
    checks++;
    if (hits != 3) begin
      failures++;
      $display("FAIL long_strobe_len got=%0d required=3", hits);
    end
    sValid3 = 1'b0;
  endtask

  task automatic test_desync_payload();
    logic [19:0] seen;
    doReset();
    send(SYNC);
    send(32'h0000_0000);
    send(DESYNC);
    tick();
    tick();
    checks++;
    if (frameStrobe !== 20'h00001 || frameData !== DESYNC || colSelect !== 16'h0001) begin
      failures++;
      $display("FAIL desync_payload fs=%h fd=%h cs=%h required 00001/FAB0FAB0/0001", frameStrobe, frameData, colSelect);
    end
    send(DESYNC);
    send(32'h0000_0101);
    send(32'h1111_1111);
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      seen |= frameStrobe;
      tick();
    end
    checks++;
    if (seen !== 20'h0 || framesWritten !== 16'd1 || frameData !== DESYNC) begin
      failures++;
      $display("FAIL desync_idle strobes=%h fw=%0d fd=%h required 00000/1/FAB0FAB0", seen, framesWritten, frameData);
    end
  endtask

  task automatic test_reset_mid_strobe();
    logic [19:0] seen;
    doReset();
    send(SYNC);
    send(32'h0000_0704);
    send(32'h0BAD_F00D);
    tick();
    tick();
    checks++;
    if (frameStrobe !== 20'h00010) begin
      failures++;
      $display("FAIL midreset_pre fs=%h required=00010", frameStrobe);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({sReady, frameData, frameStrobe, colSelect, busy, error, framesWritten} !== '0) begin
      failures++;
      $display("FAIL midreset_async rdy=%b fd=%h fs=%h cs=%h busy=%b err=%b fw=%0d required all 0",
               sReady, frameData, frameStrobe, colSelect, busy, error, framesWritten);
    end
    tick();
    tick();
    resetn = 1'b1;
    send(32'h0000_0704);
    send(32'h0BAD_F00D);
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      seen |= frameStrobe;
      tick();
    end
    checks++;
    if (seen !== 20'h0 || framesWritten !== 16'd0 || error !== 1'b0) begin
      failures++;
      $display("FAIL midreset_needsync strobes=%h fw=%0d err=%b required 00000/0/0", seen, framesWritten, error);
    end
    send(SYNC);
    send(32'h0000_0704);
    send(32'h0BAD_F00D);
    tick();
    tick();
    checks++;
    if (frameStrobe !== 20'h00010 || colSelect !== 16'h0080) begin
      failures++;
      $display("FAIL midreset_rewrite fs=%h cs=%h required 00010/0080", frameStrobe, colSelect);
    end
    tick();
    checks++;
    if (framesWritten !== 16'd1) begin
      failures++;
      $display("FAIL midreset_count got=%0d required=1", framesWritten);
    end
  endtask

  initial begin
    resetn  = 1'b1;
    sData   = '0;
    sValid  = 1'b0;
    sData3  = '0;
    sValid3 = 1'b0;
    #2;
    test_reset();
    test_basic_write();
    test_pre_sync();
    test_bad_header();
    test_long_strobe();
    test_desync_payload();
    test_reset_mid_strobe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
